// File: rtl/td4_core.sv
// td4_core: TD4 4-bit CPU, with the program counter, decode and A/B/OUT/carry datapath in one block.
// Optional build macro TD4_FETCH_REG_EN: registered IR plus a FETCH/EXEC FSM, two enabled cycles per instruction.
//
// state   | meaning  (TD4_FETCH_REG_EN only)
// S_FETCH | latch dout into IR, PC held
// S_EXEC  | execute IR, update registers and PC
module td4_core #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       en,
  output logic [3:0] adr,
  input  logic [7:0] dout,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       carry,
  output logic       halted
);
  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  logic [3:0] r_a, r_b, r_out, r_pc;
  logic       r_c, r_halt;

  logic [7:0] w_instr;
  logic       w_exec;
  logic [3:0] w_op, w_im;
  logic [4:0] w_sum;
  logic [3:0] w_a_nxt, w_b_nxt, w_out_nxt, w_pc_nxt;
  logic       w_c_nxt, w_halt_set;

`ifdef TD4_FETCH_REG_EN
  typedef enum logic {S_FETCH = 1'b0, S_EXEC = 1'b1} state_t;
  state_t     r_state;
  logic [7:0] r_ir;

  assign w_instr = r_ir;
  assign w_exec  = (r_state == S_EXEC);
`else
  assign w_instr = dout;
  assign w_exec  = 1'b1;
`endif

  assign w_op = w_instr[7:4];
  assign w_im = w_instr[3:0];

  // Non-ADD opcodes (jumps and undefined ones included) always clear carry.
  always_comb begin
    w_a_nxt    = r_a;
    w_b_nxt    = r_b;
    w_out_nxt  = r_out;
    w_pc_nxt   = r_pc + 4'd1;
    w_c_nxt    = 1'b0;
    w_halt_set = 1'b0;
    w_sum      = 5'd0;
    case (w_op)
      OP_ADD_A: begin
        w_sum   = {1'b0, r_a} + {1'b0, w_im};
        w_a_nxt = w_sum[3:0];
        w_c_nxt = w_sum[4];
      end
      OP_ADD_B: begin
        w_sum   = {1'b0, r_b} + {1'b0, w_im};
        w_b_nxt = w_sum[3:0];
        w_c_nxt = w_sum[4];
      end
      OP_MOV_AI: w_a_nxt   = w_im;
      OP_MOV_BI: w_b_nxt   = w_im;
      OP_MOV_AB: w_a_nxt   = r_b;
      OP_MOV_BA: w_b_nxt   = r_a;
      OP_IN_A:   w_a_nxt   = in_port;
      OP_IN_B:   w_b_nxt   = in_port;
      OP_OUT_B:  w_out_nxt = r_b;
      OP_OUT_I:  w_out_nxt = w_im;
      OP_JMP: begin
        w_pc_nxt   = w_im;
        w_halt_set = (w_im == r_pc);
      end
      OP_JNC: begin
        if (!r_c) begin
          w_pc_nxt   = w_im;
          w_halt_set = (w_im == r_pc);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_a    <= 4'h0;
      r_b    <= 4'h0;
      r_out  <= 4'h0;
      r_pc   <= RESET_PC;
      r_c    <= 1'b0;
      r_halt <= 1'b0;
`ifdef TD4_FETCH_REG_EN
      r_state <= S_FETCH;
      r_ir    <= 8'h00;
`endif
    end else if (en) begin
`ifdef TD4_FETCH_REG_EN
      if (r_state == S_FETCH) begin
        r_ir    <= dout;
        r_state <= S_EXEC;
      end else begin
        r_state <= S_FETCH;
      end
`endif
      if (w_exec) begin
        r_a    <= w_a_nxt;
        r_b    <= w_b_nxt;
        r_out  <= w_out_nxt;
        r_pc   <= w_pc_nxt;
        r_c    <= w_c_nxt;
        r_halt <= r_halt | w_halt_set;
      end
    end
  end

  assign adr      = r_pc;
  assign out_port = r_out;
  assign carry    = r_c;
  assign halted   = r_halt;

endmodule
